// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: opcode encodings, multiplier FSM states and the registered flag bundle.
// Base opcodes compare against aluc[3:0]; OP_MULU is the full 5-bit code.
package alu_pkg;

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_SUBU = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_LUI1 = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_SLL1 = 4'b1111;

  localparam logic [4:0] OP_MULU = 5'b10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle; done_o is high in the cycle whose step completes
// the product (WIDTH cycles after start_i) and stays high, holding prod_o, until the next start_i.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (cnt_q != FULL) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= FULL;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // The product is taken from acc_d so the final step's sum can be captured on the same edge it is formed.
  assign done_o = (cnt_q >= LAST);
  assign prod_o = acc_d;

endmodule
`endif

// File: rtl/alu_pipe.sv
// Valid/ready ALU with one output register: base ops latency 1 at 1 op/cycle, results held under backpressure.
// Define ALU_PIPE_MUL_EN to add MULU (iterative, latency WIDTH+1, in_ready low while multiplying).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW  = $clog2(WIDTH);
  localparam int HW  = WIDTH / 2;
  localparam int MSB = WIDTH - 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  flags_t           fl_q, fl_d;

  logic             busy, accept, base_ld, is_mulu, illegal_op;

  logic [WIDTH:0]   add_u;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    sh, shr_idx, sll_idx;
  logic             a_lt_b_u, a_lt_b_s, a_eq_b;
  logic [WIDTH-1:0] base_r;
  flags_t           base_fl;

  assign sh       = a[SW-1:0];
  assign shr_idx  = sh - SW'(1);
  // Modulo 2^SW this is WIDTH - sh: the source bit that lands just above the MSB on a left shift.
  assign sll_idx  = SW'(0) - sh;
  assign add_u    = {1'b0, a} + {1'b0, b};
  assign diff     = a - b;
  assign a_lt_b_u = (a < b);
  assign a_lt_b_s = ($signed(a) < $signed(b));
  assign a_eq_b   = (a == b);

  always_comb begin
    base_r  = '0;
    base_fl = '0;
    case (aluc[3:0])
      OP_ADDU: begin
        base_r        = add_u[WIDTH-1:0];
        base_fl.carry = add_u[WIDTH];
      end
      OP_SUBU: begin
        base_r        = diff;
        base_fl.carry = a_lt_b_u;
      end
      OP_ADD: begin
        base_r           = add_u[WIDTH-1:0];
        base_fl.overflow = (a[MSB] == b[MSB]) && (add_u[MSB] != a[MSB]);
      end
      OP_SUB: begin
        base_r           = diff;
        base_fl.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:           base_r = a & b;
      OP_OR:            base_r = a | b;
      OP_XOR:           base_r = a ^ b;
      OP_NOR:           base_r = ~(a | b);
      OP_LUI, OP_LUI1:  base_r = {b[HW-1:0], {HW{1'b0}}};
      OP_SLTU: begin
        base_r        = WIDTH'(a_lt_b_u);
        base_fl.carry = a_lt_b_u;
      end
      OP_SLT:           base_r = WIDTH'(a_lt_b_s);
      OP_SRA: begin
        base_r        = $signed(b) >>> sh;
        base_fl.carry = (sh != '0) && b[shr_idx];
      end
      OP_SRL: begin
        base_r        = b >> sh;
        base_fl.carry = (sh != '0) && b[shr_idx];
      end
      OP_SLL, OP_SLL1: begin
        base_r        = b << sh;
        base_fl.carry = (sh != '0) && b[sll_idx];
      end
      default: ;
    endcase
    if ((aluc[3:0] == OP_SLT) || (aluc[3:0] == OP_SLTU)) begin
      base_fl.zero = a_eq_b;
    end else begin
      base_fl.zero = (base_r == '0);
    end
    base_fl.negative = (aluc[3:0] == OP_SLT) ? base_r[0] : base_r[MSB];
  end

`ifdef ALU_PIPE_MUL_EN
  assign is_mulu = (aluc == OP_MULU);
`else
  assign is_mulu = 1'b0;
`endif
  assign illegal_op = aluc[4] && !is_mulu;

  assign in_ready = !busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign base_ld  = accept && !is_mulu;

`ifdef ALU_PIPE_MUL_EN
  state_t             state_q, state_d;
  logic               mul_start, mul_done, mul_ld;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   r_hi_q, r_hi_d;

  assign mul_start = accept && is_mulu;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // MUL may start over an unconsumed result but only leaves once the output register is free.
  always_comb begin
    state_d = state_q;
    mul_ld  = 1'b0;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL: begin
        if (mul_done && (!out_valid_q || out_ready)) begin
          state_d = ST_IDLE;
          mul_ld  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == ST_MUL);

  always_comb begin
    r_hi_d = r_hi_q;
    if (base_ld) begin
      r_hi_d = '0;
    end else if (mul_ld) begin
      r_hi_d = mul_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_q <= '0;
    end else begin
      r_hi_q <= r_hi_d;
    end
  end

  assign r_hi = r_hi_q;
`else
  assign busy = 1'b0;
  assign r_hi = '0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    fl_d        = fl_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (base_ld) begin
      out_valid_d = 1'b1;
      if (illegal_op) begin
        r_d          = '0;
        fl_d         = '0;
        fl_d.illegal = 1'b1;
      end else begin
        r_d  = base_r;
        fl_d = base_fl;
      end
    end
`ifdef ALU_PIPE_MUL_EN
    else if (mul_ld) begin
      out_valid_d   = 1'b1;
      r_d           = mul_prod[WIDTH-1:0];
      fl_d          = '0;
      fl_d.zero     = (mul_prod == '0);
      fl_d.negative = mul_prod[2*WIDTH-1];
      fl_d.carry    = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      fl_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      fl_q        <= fl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign zero      = fl_q.zero;
  assign carry     = fl_q.carry;
  assign negative  = fl_q.negative;
  assign overflow  = fl_q.overflow;
  assign illegal   = fl_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed corner cases plus random traffic against a behavioural model.
// Build with ALU_PIPE_MUL_EN defined to exercise the multiplier path.
module tb_alu_pipe;

  localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // fl = {zero, carry, negative, overflow, illegal}
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] hi;
    logic [4:0]  fl;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic [4:0]  aluc;
  logic        in_ready, out_valid;
  logic [31:0] r, r_hi;
  logic        zero, carry, negative, overflow, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .r_hi      (r_hi),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  function automatic res_t ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    res_t        o;
    longint      sx, sy, s;
    logic [63:0] wide;
    int          sh;
    logic        c, v;
    o  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(x[4:0]);
    if (op[4]) begin
      if (MUL_EN && op == 5'b10000) begin
        wide = {32'd0, x} * {32'd0, y};
        o.r  = wide[31:0];
        o.hi = wide[63:32];
        o.fl = {wide == 64'd0, o.hi != 32'd0, o.hi[31], 1'b0, 1'b0};
      end else begin
        o.fl = 5'b00001;
      end
      return o;
    end
    case (op[3:0])
      4'd0: begin wide = {32'd0, x} + {32'd0, y}; o.r = wide[31:0]; c = wide[32]; end
      4'd1: begin o.r = x - y; c = (x < y); end
      4'd2: begin s = sx + sy; o.r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: begin s = sx - sy; o.r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4: o.r = x & y;
      4'd5: o.r = x | y;
      4'd6: o.r = x ^ y;
      4'd7: o.r = ~(x | y);
      4'd8, 4'd9: o.r = y << 16;
      4'd10: begin o.r = (x < y) ? 32'd1 : 32'd0; c = (x < y); end
      4'd11: o.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: begin o.r = 32'(sy >>> sh); if (sh != 0) c = y[sh-1]; end
      4'd13: begin o.r = y >> sh; if (sh != 0) c = y[sh-1]; end
      default: begin wide = {32'd0, y} << sh; o.r = wide[31:0]; c = wide[32]; end
    endcase
    o.fl[4] = (op[3:0] == 4'd10 || op[3:0] == 4'd11) ? (x == y) : (o.r == 32'd0);
    o.fl[3] = c;
    o.fl[2] = (op[3:0] == 4'd11) ? o.r[0] : o.r[31];
    o.fl[1] = v;
    return o;
  endfunction

  // Transaction-level model: output slot contents plus a pending multiply and how many MUL cycles it has run.
  logic m_ov   = 1'b0;
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  res_t m_res  = '0;
  res_t m_pend = '0;
  wire  m_ir   = !m_busy && (!m_ov || out_ready);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov   <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt + 1 >= W && (!m_ov || out_ready)) begin
        m_busy <= 1'b0;
        m_ov   <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_cnt <= m_cnt + 1;
        if (out_ready) m_ov <= 1'b0;
      end
    end else if (in_valid && m_ir) begin
      if (MUL_EN && aluc == 5'b10000) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_pend <= ref_alu(aluc, a, b);
        if (out_ready) m_ov <= 1'b0;
      end else begin
        m_ov  <= 1'b1;
        m_res <= ref_alu(aluc, a, b);
      end
    end else if (out_ready) begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, m_ov);
    check("in_ready", in_ready, m_ir);
    if (m_ov) begin
      check("r", r, m_res.r);
      check("r_hi", r_hi, m_res.hi);
      check("flags", {zero, carry, negative, overflow, illegal}, m_res.fl);
    end
  end

  task automatic drive(input logic iv, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    aluc      = op;
    a         = x;
    b         = y;
    out_ready = ordy;
  endtask

  task automatic one_op(input string name, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input logic [4:0] exp_fl);
    drive(1'b1, op, x, y, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_r"}, r, exp_r);
    check({name, "_fl"}, {zero, carry, negative, overflow, illegal}, exp_fl);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 40);
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [4:0] rnd_aluc();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 5'($urandom_range(0, 15));
    else if (sel == 7) return 5'b10000;
    else               return 5'($urandom_range(16, 31));
  endfunction

  initial begin
    res_t p;
    int   lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    aluc      = '0;

    p = ref_alu(5'b00010, 32'h7FFF_FFFF, 32'h1);
    check("pin_add_r", p.r, 32'h8000_0000);
    check("pin_add_fl", p.fl, 5'b00110);
    p = ref_alu(5'b00001, 32'd3, 32'd5);
    check("pin_subu", {p.r, 27'd0, p.fl}, {32'hFFFF_FFFE, 27'd0, 5'b01100});
    p = ref_alu(5'b01011, 32'hFFFF_FFFF, 32'h1);
    check("pin_slt", {p.r, 27'd0, p.fl}, {32'h1, 27'd0, 5'b00100});
    p = ref_alu(5'b01100, 32'd5, 32'h8000_0010);
    check("pin_sra", {p.r, 27'd0, p.fl}, {32'hFC00_0000, 27'd0, 5'b01100});
    p = ref_alu(5'b01110, 32'h21, 32'h8000_0001);
    check("pin_sll", {p.r, 27'd0, p.fl}, {32'h2, 27'd0, 5'b01000});
    p = ref_alu(5'b10000, 32'hFFFF_FFFF, 32'h2);
    check("pin_mulu", {p.r, p.hi}, MUL_EN ? {32'hFFFF_FFFE, 32'h1} : 64'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_r", {r, r_hi}, 64'd0);
    check("reset_flags", {zero, carry, negative, overflow, illegal}, 5'b0);

    one_op("add_ovf", 5'b00010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00110);
    one_op("subu", 5'b00001, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'b01100);
    one_op("slt", 5'b01011, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00100);
    one_op("sra", 5'b01100, 32'd5, 32'h8000_0010, 32'hFC00_0000, 5'b01100);
    one_op("sll", 5'b01110, 32'h21, 32'h8000_0001, 32'h2, 5'b01000);
    one_op("illegal", 5'b11010, 32'h5, 32'h7, 32'h0, 5'b00001);

    drive(1'b1, 5'b00000, 32'd5, 32'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'b00110, 32'd1, 32'd2, 1'b0);
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_hold_r", r, 32'd11);
      check("bp_hold_fl", {zero, carry, negative, overflow, illegal}, 5'b0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    drive(1'b1, 5'b00110, 32'd1, 32'd2, 1'b1);
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_r", r, 32'd3);

    drive(1'b1, 5'b10000, 32'hFFFF_FFFF, 32'h2, 1'b1);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      drive(MUL_EN, 5'b00010, 32'd1, 32'd1, 1'b1);
      @(negedge clk);
      if (out_valid) lat = k;
      else check("mul_in_ready", in_ready, !MUL_EN);
    end
    check("mul_latency", lat, MUL_EN ? 64'd33 : 64'd1);
    check("mul_r", {r, r_hi}, MUL_EN ? {32'hFFFF_FFFE, 32'h1} : 64'd0);
    check("mul_fl", {zero, carry, negative, overflow, illegal}, MUL_EN ? 5'b01000 : 5'b00001);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);

    drive(1'b1, 5'b00010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    drive(1'b1, 5'b10000, 32'd3, 32'd4, 1'b1);
    for (int k = 1; k <= 9; k++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_r", {r, r_hi}, 64'd0);
    check("rst_mid_flags", {zero, carry, negative, overflow, illegal}, 5'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      check("rst_no_stale", out_valid, 1'b0);
    end

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, rnd_aluc(), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 40; k++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
